timer_run_controller: RTL and testbench

//  Run/pause/lap/clear sequencer for the conventional stopwatch datapath.

---
 rtl/timer_pkg.sv | 24 ++
 rtl/btn_sync_edge.sv | 34 +++
 rtl/timer_run_controller.sv | 127 ++++++++++++
 tb/tb_timer_run_controller.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the stopwatch run controller: state encoding,
// button indices and the default prescaler settings.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_LAP   = 2'b11
  } state_e;

  localparam int TICK_DIV_DEFAULT = 500000;
  localparam int DIV_W_DEFAULT    = 19;

  localparam int NUM_BTN        = 3;
  localparam int BTN_START_STOP = 0;
  localparam int BTN_LAP        = 1;
  localparam int BTN_CLEAR      = 2;

  function automatic logic is_counting(state_e s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer plus rising-edge detector for one pre-debounced button.
// All flops reset high so a button held through reset produces no event.
module btn_sync_edge (
  input  logic clock,
  input  logic resetn,
  input  logic btn,
  output logic ev
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign ev = sync2_q & ~prev_q;

endmodule

// File: rtl/timer_run_controller.sv
// Run/pause/lap/clear sequencer for one stopwatch: button events drive the
// FSM, and a prescaler issues the count-enable tick to the timer datapath.
module timer_run_controller
  import timer_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT,
  parameter int DIV_W    = DIV_W_DEFAULT
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       btn_start_stop,
  input  logic       btn_lap,
  input  logic       btn_clear,
  input  logic       at_max,
  output logic       tick_en,
  output logic       clear_count,
  output logic       freeze_display,
  output logic       running,
  output logic [1:0] state_code
);

  localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(TICK_DIV - 1);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_ev;

  assign btn_raw[BTN_START_STOP] = btn_start_stop;
  assign btn_raw[BTN_LAP]        = btn_lap;
  assign btn_raw[BTN_CLEAR]      = btn_clear;

  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      btn_sync_edge u_sync (
        .clock  (clock),
        .resetn (resetn),
        .btn    (btn_raw[gi]),
        .ev     (btn_ev[gi])
      );
    end
  endgenerate

  logic ev_ss, ev_lap, ev_clr;
  assign ev_ss  = btn_ev[BTN_START_STOP];
  assign ev_lap = btn_ev[BTN_LAP];
  assign ev_clr = btn_ev[BTN_CLEAR];

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   presc_q, presc_d;
  logic               tick_en_q, tick_en_d;
  logic               clear_count_q, clear_count_d;
  logic               freeze_q, freeze_d;
  logic               running_q, running_d;

  always_comb begin
    state_d       = state_q;
    presc_d       = presc_q;
    tick_en_d     = 1'b0;
    clear_count_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        presc_d = '0;
        if (ev_clr) begin
          clear_count_d = 1'b1;
        end else if (ev_ss) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN, ST_LAP: begin
        if (at_max || ev_ss) begin
          state_d = ST_PAUSE;
        end else if (ev_lap) begin
          state_d = (state_q == ST_RUN) ? ST_LAP : ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (ev_clr) begin
          state_d       = ST_IDLE;
          presc_d       = '0;
          clear_count_d = 1'b1;
        end else if (ev_ss && !at_max) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The prescaler only advances on edges that stay in a counting state, so
    // the edge that pauses or resumes does not consume part of the period.
    if (is_counting(state_q) && is_counting(state_d)) begin
      if (presc_q == PRESC_LAST) begin
        presc_d   = '0;
        tick_en_d = !at_max;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    freeze_d  = (state_d == ST_LAP);
    running_d = is_counting(state_d);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      presc_q       <= '0;
      tick_en_q     <= 1'b0;
      clear_count_q <= 1'b0;
      freeze_q      <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      tick_en_q     <= tick_en_d;
      clear_count_q <= clear_count_d;
      freeze_q      <= freeze_d;
      running_q     <= running_d;
    end
  end

  assign tick_en        = tick_en_q;
  assign clear_count    = clear_count_q;
  assign freeze_display = freeze_q;
  assign running        = running_q;
  assign state_code     = state_q;

endmodule

// File: tb/tb_timer_run_controller.sv
// Directed and randomized checks of timer_run_controller against a
// cycle-level behavioural model of the stopwatch rules.
module tb_timer_run_controller;

  localparam int TICK_DIV = 4;
  localparam int DIV_W    = 3;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       btn_start_stop = 1'b0;
  logic       btn_lap = 1'b0;
  logic       btn_clear = 1'b0;
  logic       at_max = 1'b0;
  logic       tick_en, clear_count, freeze_display, running;
  logic [1:0] state_code;

  int checks = 0;
  int failures = 0;

  timer_run_controller #(.TICK_DIV(TICK_DIV), .DIV_W(DIV_W)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .btn_start_stop (btn_start_stop),
    .btn_lap        (btn_lap),
    .btn_clear      (btn_clear),
    .at_max         (at_max),
    .tick_en        (tick_en),
    .clear_count    (clear_count),
    .freeze_display (freeze_display),
    .running        (running),
    .state_code     (state_code)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // Behavioural model: mode, elapsed running cycles in the current period,
  // and per-button history of sampled levels (newest first).
  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_LAP} mode_t;
  mode_t m_mode;
  int    m_phase;
  bit    m_tick, m_clr;
  bit    h_ss[$], h_lap[$], h_clr[$];

  function automatic logic [1:0] code_of(mode_t md);
    case (md)
      M_IDLE:  return 2'b00;
      M_RUN:   return 2'b01;
      M_PAUSE: return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  function automatic bit counting(mode_t md);
    return (md == M_RUN) || (md == M_LAP);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_phase = 0;
    m_tick  = 1'b0;
    m_clr   = 1'b0;
    h_ss  = '{1'b1, 1'b1, 1'b1, 1'b1};
    h_lap = '{1'b1, 1'b1, 1'b1, 1'b1};
    h_clr = '{1'b1, 1'b1, 1'b1, 1'b1};
  endtask

  // A level sampled at edge k becomes an event acted on at edge k+2.
  task automatic model_step(input bit ss, input bit lp, input bit cl, input bit am);
    bit e_ss, e_lap, e_clr;
    mode_t prev;
    h_ss.push_front(ss);
    h_lap.push_front(lp);
    h_clr.push_front(cl);
    e_ss  = h_ss[2]  && !h_ss[3];
    e_lap = h_lap[2] && !h_lap[3];
    e_clr = h_clr[2] && !h_clr[3];
    void'(h_ss.pop_back());
    void'(h_lap.pop_back());
    void'(h_clr.pop_back());

    prev   = m_mode;
    m_tick = 1'b0;
    m_clr  = 1'b0;
    if (counting(prev) && am) begin
      m_mode = M_PAUSE;
    end else begin
      case (prev)
        M_IDLE:  if (e_clr) m_clr = 1'b1; else if (e_ss) m_mode = M_RUN;
        M_RUN:   if (e_ss) m_mode = M_PAUSE; else if (e_lap) m_mode = M_LAP;
        M_LAP:   if (e_ss) m_mode = M_PAUSE; else if (e_lap) m_mode = M_RUN;
        default: begin
          if (e_clr) begin
            m_mode = M_IDLE;
            m_clr  = 1'b1;
          end else if (e_ss && !am) begin
            m_mode = M_RUN;
          end
        end
      endcase
    end

    if (m_mode == M_IDLE) begin
      m_phase = 0;
    end else if (counting(prev) && counting(m_mode)) begin
      m_phase++;
      if (m_phase == TICK_DIV) begin
        m_phase = 0;
        m_tick  = 1'b1;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".state"},   state_code,     code_of(m_mode));
    check({tag, ".running"}, running,        counting(m_mode));
    check({tag, ".freeze"},  freeze_display, (m_mode == M_LAP));
    check({tag, ".tick"},    tick_en,        m_tick);
    check({tag, ".clear"},   clear_count,    m_clr);
  endtask

  task automatic cycle(input bit ss, input bit lp, input bit cl, input bit am);
    @(negedge clock);
    btn_start_stop = ss;
    btn_lap        = lp;
    btn_clear      = cl;
    at_max         = am;
    @(posedge clock);
    #1;
    model_step(ss, lp, cl, am);
    compare_all("model");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".state"},   state_code,     2'b00);
    check({tag, ".running"}, running,        1'b0);
    check({tag, ".freeze"},  freeze_display, 1'b0);
    check({tag, ".tick"},    tick_en,        1'b0);
    check({tag, ".clear"},   clear_count,    1'b0);
  endtask

  initial begin
    bit found;
    bit r_ss, r_lap, r_clr, r_am;

    // Reset with start/stop held.
    btn_start_stop = 1'b1;
    model_reset();
    repeat (3) @(negedge clock);
    check_reset_outputs("reset_held");
    resetn = 1'b1;

    // Keep holding after reset: no event.
    repeat (5) cycle(1, 0, 0, 0);
    check("held_no_start", state_code, 2'b00);

    // Release, then press: RUN on the third edge.
    repeat (3) cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check("press_edge1", state_code, 2'b00);
    cycle(1, 0, 0, 0);
    check("press_edge2", state_code, 2'b00);
    cycle(1, 0, 0, 0);
    check("press_edge3", state_code, 2'b01);
    check("start_running", running, 1'b1);

    // Tick cadence: every 4 clocks, first one 4 clocks after entering RUN.
    for (int i = 1; i <= 8; i++) begin
      cycle(0, 0, 0, 0);
      check("tick_cadence", tick_en, (i % TICK_DIV) == 0);
    end

    // Lap in, lap out.
    cycle(0, 1, 0, 0);
    repeat (2) cycle(0, 0, 0, 0);
    check("lap_state", state_code, 2'b11);
    check("lap_freeze", freeze_display, 1'b1);
    repeat (4) cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    repeat (2) cycle(0, 0, 0, 0);
    check("unlap_state", state_code, 2'b01);
    check("unlap_freeze", freeze_display, 1'b0);

    // Pause two clocks into a period, then resume.
    found = 1'b0;
    for (int i = 0; i < 2 * TICK_DIV && !found; i++) begin
      cycle(0, 0, 0, 0);
      found = tick_en;
    end
    check("find_tick", found, 1'b1);
    cycle(1, 0, 0, 0);
    repeat (2) cycle(0, 0, 0, 0);
    check("pause_state", state_code, 2'b10);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 0, 0);
      check("pause_no_tick", tick_en, 1'b0);
    end
    cycle(1, 0, 0, 0);
    repeat (2) cycle(0, 0, 0, 0);
    check("resume_state", state_code, 2'b01);
    cycle(0, 0, 0, 0);
    check("resume_tick1", tick_en, 1'b0);
    cycle(0, 0, 0, 0);
    check("resume_tick2", tick_en, 1'b1);

    // Terminal value forces PAUSE; start/stop is dropped while at_max.
    cycle(0, 0, 0, 1);
    check("atmax_pause", state_code, 2'b10);
    check("atmax_tick", tick_en, 1'b0);
    cycle(1, 0, 0, 1);
    repeat (4) cycle(0, 0, 0, 1);
    check("atmax_drop_start", state_code, 2'b10);
    repeat (2) cycle(0, 0, 0, 0);
    check("atmax_still_pause", state_code, 2'b10);

    // Clear and start/stop together in PAUSE: clear wins.
    cycle(1, 0, 1, 0);
    cycle(0, 0, 0, 0);
    check("clr_edge2", clear_count, 1'b0);
    cycle(0, 0, 0, 0);
    check("clr_state", state_code, 2'b00);
    check("clr_pulse", clear_count, 1'b1);
    check("clr_presc", dut.presc_q, 0);
    cycle(0, 0, 0, 0);
    check("clr_single", clear_count, 1'b0);

    // Clear in IDLE pulses but stays.
    cycle(0, 0, 1, 0);
    repeat (2) cycle(0, 0, 0, 0);
    check("idle_clr_pulse", clear_count, 1'b1);
    check("idle_clr_state", state_code, 2'b00);
    cycle(0, 0, 0, 0);

    // Asynchronous reset mid-run.
    cycle(1, 0, 0, 0);
    repeat (4) cycle(0, 0, 0, 0);
    check("prereset_run", running, 1'b1);
    @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(negedge clock);
    resetn = 1'b1;

    // Randomized levels with slowly changing buttons and at_max.
    r_ss = 0; r_lap = 0; r_clr = 0; r_am = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) r_ss  = ~r_ss;
      if ($urandom_range(0, 6) == 0) r_lap = ~r_lap;
      if ($urandom_range(0, 11) == 0) r_clr = ~r_clr;
      if ($urandom_range(0, 19) == 0) r_am  = ~r_am;
      cycle(r_ss, r_lap, r_clr, r_am);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
